gray_stream_gen: RTL



---
 rtl/gray_stream_gen_pkg.sv | 26 ++
 rtl/gray_stream_gen_video_hv_counter.sv | 40 ++++
 rtl/gray_stream_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gray_stream_gen_pkg.sv
// Shared FSM encoding and default video geometry for the grayscale stream generator.
package gray_stream_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BLANK  = 4;
  localparam int DEF_ADDR_W   = 17;

  function automatic int h_total(input int h_active, input int h_blank);
    return h_active + h_blank;
  endfunction

  function automatic int v_total(input int v_active, input int v_blank);
    return v_active + v_blank;
  endfunction

endpackage

// File: rtl/gray_stream_gen_video_hv_counter.sv
// Raster position counter: h_cnt walks one line, v_cnt walks blanking plus active lines.
module video_hv_counter
  import gray_stream_gen_pkg::*;
#(
  parameter int H_TOTAL = h_total(DEF_H_ACTIVE, DEF_H_BLANK),
  parameter int V_TOTAL = v_total(DEF_V_ACTIVE, DEF_V_BLANK),
  parameter int H_W     = $clog2(H_TOTAL),
  parameter int V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           line_end,
  output logic           frame_end
);

  assign line_end  = (h_cnt == H_W'(H_TOTAL - 1));
  assign frame_end = line_end && (v_cnt == V_W'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (line_end) begin
        h_cnt <= '0;
        if (frame_end) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_stream_gen.sv
// Frame-RAM raster reader producing the blanked grayscale stream for the edge filter.
module gray_stream_gen
  import gray_stream_gen_pkg::*;
#(
  parameter int          H_ACTIVE       = DEF_H_ACTIVE,
  parameter int          V_ACTIVE       = DEF_V_ACTIVE,
  parameter int          H_BLANK        = DEF_H_BLANK,
  parameter int          H_SYNC         = DEF_H_SYNC,
  parameter int          V_SYNC         = DEF_V_SYNC,
  parameter int          V_BLANK        = DEF_V_BLANK,
  parameter int          ADDR_W         = DEF_ADDR_W,
  parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              gray_valid,
  output logic [7:0]        gray_data,
  output logic              hsync,
  output logic              vsync,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_BLANK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_BLANK);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  state_e            state_p0;
  logic              pending_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [H_W-1:0]    h_p0;
  logic [V_W-1:0]    v_p0;
  logic              line_end_p0;
  logic              frame_end_p0;
  logic              go;
  logic              run_p0;
  logic              in_vblank_p0;
  logic              in_active_p0;
  logic              last_p0;
  logic              rd_p0;
  logic              vld_p0;
  logic              hs_p0;
  logic              vs_p0;
  logic              vld_p1;
  logic              last_p1;

  // p0: raster position one cycle ahead of the ports; IDLE with a request acts as VBLANK (0,0)
  assign go           = start | continuous;
  assign run_p0       = (state_p0 != ST_IDLE) | go;
  assign in_vblank_p0 = (state_p0 == ST_VBLANK) | ((state_p0 == ST_IDLE) & go);
  assign in_active_p0 = (state_p0 == ST_ACTIVE);
  assign last_p0      = in_active_p0 & frame_end_p0;

  assign vld_p0 = in_active_p0 && (h_p0 >= H_W'(H_BLANK));
  assign rd_p0  = in_active_p0 && (h_p0 >= H_W'(H_BLANK - 1)) && (h_p0 <= H_W'(H_TOTAL - 2));
  assign hs_p0  = in_active_p0 && (h_p0 >= H_W'(H_BLANK - 1)) &&
                  (h_p0 <= H_W'(H_BLANK + H_SYNC - 2));
  assign vs_p0  = in_vblank_p0 && (v_p0 < V_W'(V_SYNC));

  video_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_W     (H_W),
    .V_W     (V_W)
  ) u_hv (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run_p0),
    .h_cnt     (h_p0),
    .v_cnt     (v_p0),
    .line_end  (line_end_p0),
    .frame_end (frame_end_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0   <= ST_IDLE;
      pending_p0 <= 1'b0;
      addr_p0    <= '0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (go) state_p0 <= ST_VBLANK;
        end
        ST_VBLANK: begin
          if (line_end_p0 && (v_p0 == V_W'(V_BLANK - 1))) state_p0 <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (frame_end_p0) state_p0 <= (continuous | pending_p0 | start) ? ST_VBLANK : ST_IDLE;
        end
        default: state_p0 <= ST_IDLE;
      endcase

      // a start arriving during a frame is held as a single queued request
      if (last_p0) begin
        pending_p0 <= 1'b0;
      end else if (start && (state_p0 != ST_IDLE)) begin
        pending_p0 <= 1'b1;
      end

      if (last_p0) begin
        addr_p0 <= '0;
      end else if (rd_p0) begin
        addr_p0 <= addr_p0 + 1'b1;
      end
    end
  end

  // p1: port registers; frame_done trails the last pixel by one cycle via last_p1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      vld_p1     <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      busy       <= 1'b0;
      last_p1    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= FRAME_CNT_INIT;
    end else begin
      rd_en      <= rd_p0;
      rd_addr    <= rd_p0 ? addr_p0 : '0;
      vld_p1     <= vld_p0;
      hsync      <= hs_p0;
      vsync      <= vs_p0;
      busy       <= run_p0 | last_p1;
      last_p1    <= last_p0;
      frame_done <= last_p1;
      if (last_p1) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // the RAM output register is the pixel register, so it is only gated here
  assign gray_valid = vld_p1;
  assign gray_data  = vld_p1 ? rd_data : 8'h00;

endmodule
